// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl -- machine-mode trap controller
//
// Takes synchronous exceptions and one level-sensitive external interrupt and
// holds the trap CSRs: mstatus, mie, mip, mtvec, mepc and mcause. It drives
// single-cycle redirect pulses into the fetch PC mux. That mux gives trap entry
// priority over trap return, and trap return priority over a branch.
//
// Optional feature: define TRAP_VECTORED_EN to enable vectored interrupt mode.
// In that mode mtvec[1:0] is writable with 0 or 1; writes of 2 or 3 store 0.
// When mtvec[1:0]==1 and the trap is an interrupt, the target is
// base + 4*cause. Exceptions always go to base. When TRAP_VECTORED_EN is not
// defined, mtvec[1:0] is hardwired to 0 and only direct mode exists.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   exc_valid        synchronous exception this cycle
//   exc_cause        exception code (2 illegal, 3 ebreak, 11 ecall)
//   exc_pc           PC of the faulting instruction
//   irq_ext          external interrupt level, already synchronous to clk
//   pc_resume        PC of the next unexecuted instruction (mepc on interrupt)
//   mret             mret retired this cycle
//   csr_we/addr/wdata  CSR write port
//   csr_rdata        CSR read data, combinational on csr_addr
//   interruptSignal  trap-entry redirect pulse
//   PC_TrapTrigger   trap target PC (continuous view of mtvec)
//   trapReturn       mret redirect pulse
//   PC_TrapReturn    return target (continuous view of mepc)
//   trap_flush       flush younger stages (entry or return pulse)
//   state_dbg        current FSM state (0 RUN, 1 ENTRY, 2 RETURN)
//
// Handshake: this block has no valid/ready handshakes. Every event input is a
// single-cycle qualifier that is sampled only in RUN. An event that arrives in
// ENTRY or RETURN is dropped, because the pipeline is being flushed.
// -----------------------------------------------------------------------------
module trap_ctrl #(
   parameter int            N       = 64,
   parameter logic [N-1:0]  RST_VEC = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          exc_valid,
   input  logic [3:0]    exc_cause,
   input  logic [N-1:0]  exc_pc,
   input  logic          irq_ext,
   input  logic [N-1:0]  pc_resume,
   input  logic          mret,
   input  logic          csr_we,
   input  logic [11:0]   csr_addr,
   input  logic [N-1:0]  csr_wdata,
   output logic [N-1:0]  csr_rdata,
   output logic          interruptSignal,
   output logic [N-1:0]  PC_TrapTrigger,
   output logic          trapReturn,
   output logic [N-1:0]  PC_TrapReturn,
   output logic          trap_flush,
   output logic [1:0]    state_dbg
);

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MIP     = 12'h344;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_ENTRY  = 2'd1,
      ST_RETURN = 2'd2
   } state_t;

   state_t        state;
   logic          st_mie;     // mstatus.MIE
   logic          st_mpie;    // mstatus.MPIE
   logic          meie;       // mie.MEIE
   logic [N-1:0]  mtvec;
   logic [N-1:0]  mepc;
   logic [N-1:0]  mcause;

   // Event decode. The priority is exception, then interrupt, then mret.
   logic take_exc, take_irq, take_entry, take_ret;
   assign take_exc   = (state == ST_RUN) && exc_valid;
   assign take_irq   = (state == ST_RUN) && !exc_valid && irq_ext && st_mie && meie;
   assign take_entry = take_exc || take_irq;
   assign take_ret   = (state == ST_RUN) && !take_entry && mret;

   // A CSR write loses only to a trap update of the same CSR on the same edge.
   // Writes to every other CSR still land.
   logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause;
   assign wr_mstatus = csr_we && (csr_addr == A_MSTATUS) && !take_entry && !take_ret;
   assign wr_mie     = csr_we && (csr_addr == A_MIE);
   assign wr_mtvec   = csr_we && (csr_addr == A_MTVEC);
   assign wr_mepc    = csr_we && (csr_addr == A_MEPC)   && !take_entry;
   assign wr_mcause  = csr_we && (csr_addr == A_MCAUSE) && !take_entry;

   // mtvec as stored: the mode bits are kept only when vectored mode exists.
   logic [N-1:0] mtvec_wval;
   logic [N-1:0] mtvec_rst;
`ifdef TRAP_VECTORED_EN
   assign mtvec_wval = {csr_wdata[N-1:2], (csr_wdata[1:0] == 2'b01) ? 2'b01 : 2'b00};
   assign mtvec_rst  = {RST_VEC[N-1:2], (RST_VEC[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
   assign mtvec_wval = {csr_wdata[N-1:2], 2'b00};
   assign mtvec_rst  = {RST_VEC[N-1:2], 2'b00};
`endif

   logic [N-1:0] entry_mepc;
   logic [N-1:0] entry_mcause;
   assign entry_mepc   = take_exc ? {exc_pc[N-1:2], 2'b00} : {pc_resume[N-1:2], 2'b00};
   assign entry_mcause = take_exc ? {{(N-4){1'b0}}, exc_cause}
                                  : {1'b1, {(N-5){1'b0}}, 4'd11};

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_RUN;
         st_mie          <= 1'b0;
         st_mpie         <= 1'b0;
         meie            <= 1'b0;
         mtvec           <= mtvec_rst;
         mepc            <= '0;
         mcause          <= '0;
         interruptSignal <= 1'b0;
         trapReturn      <= 1'b0;
         trap_flush      <= 1'b0;
      end else begin
         if (wr_mstatus) begin
            st_mie  <= csr_wdata[3];
            st_mpie <= csr_wdata[7];
         end
         if (wr_mie)    meie   <= csr_wdata[11];
         if (wr_mtvec)  mtvec  <= mtvec_wval;
         if (wr_mepc)   mepc   <= {csr_wdata[N-1:2], 2'b00};
         if (wr_mcause) mcause <= csr_wdata;

         interruptSignal <= 1'b0;
         trapReturn      <= 1'b0;
         trap_flush      <= 1'b0;

         case (state)
            ST_RUN: begin
               if (take_entry) begin
                  state           <= ST_ENTRY;
                  interruptSignal <= 1'b1;
                  trap_flush      <= 1'b1;
                  mepc            <= entry_mepc;
                  mcause          <= entry_mcause;
                  st_mpie         <= st_mie;
                  st_mie          <= 1'b0;
               end else if (take_ret) begin
                  state      <= ST_RETURN;
                  trapReturn <= 1'b1;
                  trap_flush <= 1'b1;
                  st_mie     <= st_mpie;
                  st_mpie    <= 1'b1;
               end
            end
            // ENTRY and RETURN each last one cycle and ignore new events.
            default: state <= ST_RUN;
         endcase
      end
   end

   // Redirect targets are continuous views, so a CSR write that lands in RUN
   // is visible to fetch on the following cycle.
   logic [N-1:0] tvec_base;
   assign tvec_base = {mtvec[N-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
   always_comb begin
      PC_TrapTrigger = tvec_base;
      if ((mtvec[1:0] == 2'b01) && mcause[N-1])
         PC_TrapTrigger = tvec_base + {{(N-6){1'b0}}, mcause[3:0], 2'b00};
   end
`else
   assign PC_TrapTrigger = tvec_base;
`endif

   assign PC_TrapReturn = mepc;
   assign state_dbg     = state;

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         A_MSTATUS: begin
            csr_rdata[3] = st_mie;
            csr_rdata[7] = st_mpie;
         end
         A_MIE:    csr_rdata[11] = meie;
         A_MIP:    csr_rdata[11] = irq_ext;
         A_MTVEC:  csr_rdata = mtvec;
         A_MEPC:   csr_rdata = mepc;
         A_MCAUSE: csr_rdata = mcause;
         default:  csr_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl -- self-checking bench for trap_ctrl
//
// Every redirect pulse the bench expects is pushed to exp_q when the causing
// event is driven. A negedge monitor pops and compares each pulse that the DUT
// produces, as {trap_flush, trapReturn, interruptSignal, target}.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

   localparam int           N       = 64;
   localparam logic [N-1:0] RST_VEC = 64'h80;

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MIP     = 12'h344;

   localparam logic [N-1:0] IRQ_CAUSE = 64'h8000_0000_0000_000B;

   logic          clk;
   logic          reset;
   logic          exc_valid;
   logic [3:0]    exc_cause;
   logic [N-1:0]  exc_pc;
   logic          irq_ext;
   logic [N-1:0]  pc_resume;
   logic          mret;
   logic          csr_we;
   logic [11:0]   csr_addr;
   logic [N-1:0]  csr_wdata;
   logic [N-1:0]  csr_rdata;
   logic          interruptSignal;
   logic [N-1:0]  PC_TrapTrigger;
   logic          trapReturn;
   logic [N-1:0]  PC_TrapReturn;
   logic          trap_flush;
   logic [1:0]    state_dbg;

   int n_total = 0;
   int n_bad   = 0;

   logic [N+2:0] exp_q[$];

   trap_ctrl #(.N(N), .RST_VEC(RST_VEC)) dut (
      .clk(clk), .reset(reset),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
      .irq_ext(irq_ext), .pc_resume(pc_resume), .mret(mret),
      .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_rdata(csr_rdata),
      .interruptSignal(interruptSignal), .PC_TrapTrigger(PC_TrapTrigger),
      .trapReturn(trapReturn), .PC_TrapReturn(PC_TrapReturn),
      .trap_flush(trap_flush), .state_dbg(state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pulse monitor: each redirect pulse must match the head of exp_q.
   always @(negedge clk) begin
      logic [N+2:0] obs;
      if (interruptSignal || trapReturn || trap_flush) begin
         obs = {trap_flush, trapReturn, interruptSignal,
                interruptSignal ? PC_TrapTrigger : PC_TrapReturn};
         if (exp_q.size() == 0) check("unexpected_pulse", obs, '0);
         else                   check("pulse", obs, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [N-1:0] d);
      csr_we = 1'b1; csr_addr = a; csr_wdata = d;
      step();
      csr_we = 1'b0;
   endtask

   task automatic csr_chk(input string tag, input logic [11:0] a, input logic [N-1:0] e);
      csr_addr = a;
      #1;
      check(tag, csr_rdata, e);
   endtask

   function automatic logic [N+2:0] exp_entry(input logic [N-1:0] tgt);
      return {3'b101, tgt};
   endfunction

   function automatic logic [N+2:0] exp_ret(input logic [N-1:0] tgt);
      return {3'b110, tgt};
   endfunction

   // Drive one exception. On return, the bench sits in the ENTRY cycle.
   task automatic do_exc(input logic [3:0] c, input logic [N-1:0] pc, input logic [N-1:0] tgt);
      exc_valid = 1'b1; exc_cause = c; exc_pc = pc;
      exp_q.push_back(exp_entry(tgt));
      step();
      exc_valid = 1'b0;
      check("exc_latency", interruptSignal, 1'b1);
   endtask

   task automatic do_mret(input logic [N-1:0] tgt);
      mret = 1'b1;
      exp_q.push_back(exp_ret(tgt));
      step();
      mret = 1'b0;
      check("mret_latency", trapReturn, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0]   causes[3];
      logic [N-1:0] rpc, rtv;
      logic [N-1:0] vec_tgt;
      causes[0] = 4'd2; causes[1] = 4'd3; causes[2] = 4'd11;

      reset = 1'b1; exc_valid = 1'b0; exc_cause = '0; exc_pc = '0;
      irq_ext = 1'b0; pc_resume = '0; mret = 1'b0;
      csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
      repeat (3) step();
      reset = 1'b0;

      // Reset state
      check("rst_flush", {interruptSignal, trapReturn, trap_flush}, 3'b000);
      check("rst_state", state_dbg, 2'd0);
      check("rst_trigger", PC_TrapTrigger, RST_VEC);
      csr_chk("rst_mstatus", A_MSTATUS, '0);
      csr_chk("rst_mie", A_MIE, '0);
      csr_chk("rst_mtvec", A_MTVEC, RST_VEC);
      csr_chk("rst_mepc", A_MEPC, '0);
      csr_chk("rst_mcause", A_MCAUSE, '0);

      // ecall with mtvec=0x100
      csr_wr(A_MTVEC, 64'h100);
      check("mtvec_visible", PC_TrapTrigger, 64'h100);
      do_exc(4'd11, 64'h40, 64'h100);
      csr_chk("ecall_mepc", A_MEPC, 64'h40);
      csr_chk("ecall_mcause", A_MCAUSE, 64'd11);
      csr_chk("ecall_mstatus", A_MSTATUS, '0);
      step();

      // External interrupt
      csr_wr(A_MSTATUS, 64'h8);
      csr_wr(A_MIE, 64'h800);
      irq_ext = 1'b1; pc_resume = 64'h84;
      exp_q.push_back(exp_entry(64'h100));
      step();
      irq_ext = 1'b0;
      check("irq_latency", interruptSignal, 1'b1);
      csr_chk("irq_mepc", A_MEPC, 64'h84);
      csr_chk("irq_mcause", A_MCAUSE, IRQ_CAUSE);
      csr_chk("irq_mstatus", A_MSTATUS, 64'h80);
      step();

      // mret from the interrupt handler
      do_mret(64'h84);
      step();
      check("mret_target", PC_TrapReturn, 64'h84);
      csr_chk("mret_mstatus", A_MSTATUS, 64'h88);

      // Exception and interrupt on the same cycle: the exception wins. The
      // interrupt is taken after the following mret.
      irq_ext = 1'b1; pc_resume = 64'h90;
      do_exc(4'd2, 64'h50, 64'h100);
      csr_chk("both_mcause", A_MCAUSE, 64'd2);
      csr_chk("both_mepc", A_MEPC, 64'h50);
      csr_chk("both_mstatus", A_MSTATUS, 64'h80);
      step();
      step();
      exp_q.push_back(exp_ret(64'h50));
      exp_q.push_back(exp_entry(64'h100));
      mret = 1'b1;
      step();
      mret = 1'b0;
      check("both_mret", trapReturn, 1'b1);
      step();
      step();
      check("deferred_irq", interruptSignal, 1'b1);
      irq_ext = 1'b0;
      csr_chk("deferred_mepc", A_MEPC, 64'h90);
      csr_chk("deferred_mcause", A_MCAUSE, IRQ_CAUSE);
      csr_chk("deferred_mstatus", A_MSTATUS, 64'h80);
      step();

      // Nested exception in the handler, with a same-edge mepc write that must be dropped
      csr_we = 1'b1; csr_addr = A_MEPC; csr_wdata = 64'h200;
      do_exc(4'd3, 64'h60, 64'h100);
      csr_we = 1'b0;
      csr_chk("nested_mepc", A_MEPC, 64'h60);
      csr_chk("nested_mcause", A_MCAUSE, 64'd3);
      csr_chk("nested_mstatus", A_MSTATUS, 64'h0);
      step();

      // A same-edge write to an unrelated CSR (mtvec) still lands
      csr_we = 1'b1; csr_addr = A_MTVEC; csr_wdata = 64'h140;
      do_exc(4'd11, 64'h70, 64'h140);
      csr_we = 1'b0;
      csr_chk("coll_mtvec", A_MTVEC, 64'h140);
      csr_chk("coll_mepc", A_MEPC, 64'h70);
      step();

      // mret outside a handler, with a same-edge mstatus write that must be dropped
      csr_we = 1'b1; csr_addr = A_MSTATUS; csr_wdata = 64'h8;
      do_mret(64'h70);
      csr_we = 1'b0;
      csr_chk("plain_mret_mstatus", A_MSTATUS, 64'h80);
      step();

      // Plain CSR accesses
      csr_wr(A_MEPC, 64'h203);
      check("mepc_visible", PC_TrapReturn, 64'h200);
      csr_wr(A_MCAUSE, 64'h5);
      csr_chk("mcause_wr", A_MCAUSE, 64'h5);
      irq_ext = 1'b1;
      csr_chk("mip_set", A_MIP, 64'h800);
      irq_ext = 1'b0;
      csr_chk("mip_clr", A_MIP, 64'h0);
      csr_wr(12'h7C0, '1);
      csr_chk("unknown_csr", 12'h7C0, '0);
      csr_wr(A_MSTATUS, '1);
      csr_chk("mstatus_mask", A_MSTATUS, 64'h88);
      csr_wr(A_MSTATUS, '0);
      csr_wr(A_MIE, '1);
      csr_chk("mie_mask", A_MIE, 64'h800);

      // mtvec mode bits and vectored interrupt target
      csr_wr(A_MTVEC, 64'h101);
`ifdef TRAP_VECTORED_EN
      csr_chk("mtvec_mode", A_MTVEC, 64'h101);
      vec_tgt = 64'h12C;
`else
      csr_chk("mtvec_mode", A_MTVEC, 64'h100);
      vec_tgt = 64'h100;
`endif
      do_exc(4'd2, 64'h10, 64'h100);
      step();
      do_mret(64'h10);
      step();
      csr_wr(A_MSTATUS, 64'h8);
      irq_ext = 1'b1; pc_resume = 64'h20;
      exp_q.push_back(exp_entry(vec_tgt));
      step();
      irq_ext = 1'b0;
      check("vec_irq", interruptSignal, 1'b1);
      step();
      csr_wr(A_MTVEC, 64'h103);
      csr_chk("mtvec_bad_mode", A_MTVEC, 64'h100);

      // Random exceptions
      for (int i = 0; i < 8; i++) begin
         rpc = {$urandom(), $urandom()} & ~64'h3;
         rtv = {$urandom(), $urandom()} & ~64'h3;
         csr_wr(A_MTVEC, rtv);
         do_exc(causes[$urandom_range(0, 2)], rpc, rtv);
         csr_chk("rand_mepc", A_MEPC, rpc);
         check("rand_ret_view", PC_TrapReturn, rpc);
         csr_chk("rand_mcause_hi", A_MCAUSE & 64'hFFFF_FFFF_FFFF_FFF0, '0);
         step();
      end

      // Reset asserted during ENTRY
      do_exc(4'd11, 64'h44, rtv);
      reset = 1'b1;
      step();
      check("rst_entry_pulse", {interruptSignal, trap_flush}, 2'b00);
      check("rst_entry_state", state_dbg, 2'd0);
      csr_chk("rst_entry_mtvec", A_MTVEC, RST_VEC);
      csr_chk("rst_entry_mepc", A_MEPC, '0);
      csr_chk("rst_entry_mcause", A_MCAUSE, '0);
      csr_chk("rst_entry_mstatus", A_MSTATUS, '0);
      reset = 1'b0;
      repeat (3) step();

      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
